// File: rtl/dc_ipu_line_seq.sv
// dc_ipu_line_seq: line-level scheduler for the IPU gather stage.
// Steps a fixed-point source-Y accumulator once per output line. For each line
// it requests a 4-row window from the Buffering Unit, starts the gather unit,
// counts output quads, and then aborts the gather unit to close the line.
// Optional build macro: DC_IPU_LINE_SEQ_STATS_EN enables the RUN stall counter.
module dc_ipu_line_seq #(
  parameter int TEX_SIZE_WIDTH  = 12,
  parameter int TEX_FRACT_WIDTH = 8,
  parameter int CLAMP_CTL_WIDTH = 3
) (
  input  logic                                              clk,
  input  logic                                              nreset,
  input  logic                                              frame_start,
  input  logic                                              frame_abort,
  input  logic        [TEX_SIZE_WIDTH-1:0]                  cfg_tex_width,
  input  logic        [TEX_SIZE_WIDTH-1:0]                  cfg_tex_height,
  input  logic        [TEX_SIZE_WIDTH-1:0]                  cfg_out_width,
  input  logic        [TEX_SIZE_WIDTH-1:0]                  cfg_out_height,
  input  logic signed [TEX_SIZE_WIDTH+TEX_FRACT_WIDTH-1:0]  cfg_y_init,
  input  logic        [TEX_SIZE_WIDTH+TEX_FRACT_WIDTH-1:0]  cfg_y_step,
  output logic                                              bu_line_valid,
  input  logic                                              bu_line_ready,
  output logic        [TEX_SIZE_WIDTH-1:0]                  bu_line_y,
  output logic                                              g_ctl_start,
  output logic                                              g_ctl_abort,
  output logic signed [CLAMP_CTL_WIDTH-1:0]                 g_ctl_clamp_y,
  output logic        [TEX_SIZE_WIDTH-1:0]                  g_ctl_tex_width,
  output logic        [TEX_FRACT_WIDTH-1:0]                 line_fract_y,
  input  logic                                              quad_xfer,
  output logic                                              busy,
  output logic                                              frame_done,
  output logic        [31:0]                                stat_stall_cycles
);

  localparam int YW = TEX_SIZE_WIDTH + TEX_FRACT_WIDTH;
  localparam int AW = TEX_SIZE_WIDTH + 1;

  localparam logic signed [AW-1:0] ONE    = AW'(1);
  localparam logic signed [AW-1:0] FOUR   = AW'(4);
  localparam logic signed [AW-1:0] CL_MAX = AW'(3);
  localparam logic signed [AW-1:0] CL_MIN = AW'(-3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_END   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic signed [YW-1:0]              y_acc;
  logic        [YW-1:0]              step_cfg;
  logic        [TEX_SIZE_WIDTH-1:0]  h_cfg;
  logic        [TEX_SIZE_WIDTH-1:0]  tw_cfg;
  logic        [TEX_SIZE_WIDTH-1:0]  ow_cfg;
  logic        [TEX_SIZE_WIDTH-1:0]  oh_cfg;
  logic        [TEX_SIZE_WIDTH-1:0]  line_cnt;
  logic        [TEX_SIZE_WIDTH-1:0]  quad_cnt;
  logic                              abort_pend;

  logic signed [AW-1:0]              y_int, r0, lo, h_max, win_y, win_d;
  logic signed [CLAMP_CTL_WIDTH-1:0] win_clamp;
  logic                              hs, last_quad, last_line;

  // Saturate the window offset to the signed clamp-code range -3..+3.
  function automatic logic signed [CLAMP_CTL_WIDTH-1:0] sat_clamp(input logic signed [AW-1:0] d);
    logic signed [AW-1:0] s;
    if (d > CL_MAX)      s = CL_MAX;
    else if (d < CL_MIN) s = CL_MIN;
    else                 s = d;
    return s[CLAMP_CTL_WIDTH-1:0];
  endfunction

  // Window placement: the 4-row window starts one row above the integer Y and
  // is pushed inside the texture; the push distance becomes the clamp code.
  always_comb begin
    y_int     = {y_acc[YW-1], y_acc[YW-1:TEX_FRACT_WIDTH]};  // y_acc >>> FRACT, sign-extended
    r0        = y_int - ONE;
    lo        = r0[AW-1] ? '0 : r0;
    h_max     = $signed({1'b0, h_cfg}) - FOUR;
    win_y     = (lo > h_max) ? h_max : lo;
    win_d     = r0 - win_y;
    win_clamp = sat_clamp(win_d);
  end

  assign hs        = bu_line_valid && bu_line_ready;
  assign last_quad = (quad_cnt == ow_cfg - TEX_SIZE_WIDTH'(1));
  assign last_line = (line_cnt == oh_cfg - TEX_SIZE_WIDTH'(1));
  assign bu_line_y = bu_line_valid ? win_y[TEX_SIZE_WIDTH-1:0] : '0;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt     = state;
    bu_line_valid = 1'b0;
    g_ctl_start   = 1'b0;
    g_ctl_abort   = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: if (frame_start) state_nxt = S_REQ;
      S_REQ: begin
        if (abort_pend) begin
          state_nxt = S_DONE;
        end else begin
          bu_line_valid = 1'b1;
          // An accepted request is honoured even if an abort arrives with it;
          // the abort is then deferred to the end of that line.
          if (bu_line_ready)    state_nxt = S_START;
          else if (frame_abort) state_nxt = S_DONE;
        end
      end
      S_START: begin
        g_ctl_start = 1'b1;
        state_nxt   = S_RUN;
      end
      S_RUN: if (quad_xfer && last_quad) state_nxt = S_END;
      S_END: begin
        g_ctl_abort = 1'b1;
        state_nxt   = (last_line || abort_pend || frame_abort) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame configuration, Y accumulator, counters and gather line controls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      y_acc           <= '0;
      step_cfg        <= '0;
      h_cfg           <= '0;
      tw_cfg          <= '0;
      ow_cfg          <= '0;
      oh_cfg          <= '0;
      line_cnt        <= '0;
      quad_cnt        <= '0;
      abort_pend      <= 1'b0;
      g_ctl_clamp_y   <= '0;
      g_ctl_tex_width <= '0;
      line_fract_y    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            y_acc      <= cfg_y_init;
            step_cfg   <= cfg_y_step;
            h_cfg      <= cfg_tex_height;
            tw_cfg     <= cfg_tex_width;
            ow_cfg     <= cfg_out_width;
            oh_cfg     <= cfg_out_height;
            line_cnt   <= '0;
            abort_pend <= 1'b0;
          end
        end
        S_REQ: begin
          // Line controls are captured on the handshake so they are already
          // valid during the start pulse and stay put for the whole line.
          if (hs) begin
            g_ctl_clamp_y   <= win_clamp;
            g_ctl_tex_width <= tw_cfg;
            line_fract_y    <= y_acc[TEX_FRACT_WIDTH-1:0];
            if (frame_abort) abort_pend <= 1'b1;
          end
        end
        S_START: begin
          quad_cnt <= '0;
          if (frame_abort) abort_pend <= 1'b1;
        end
        S_RUN: begin
          if (quad_xfer)   quad_cnt   <= quad_cnt + TEX_SIZE_WIDTH'(1);
          if (frame_abort) abort_pend <= 1'b1;
        end
        S_END: begin
          y_acc    <= y_acc + $signed(step_cfg);  // wraps at full width
          line_cnt <= line_cnt + TEX_SIZE_WIDTH'(1);
          if (frame_abort) abort_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DC_IPU_LINE_SEQ_STATS_EN
  logic [31:0] stall_cnt;

  // Count RUN cycles without a quad transfer; saturates, cleared per frame.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                                  stall_cnt <= '0;
    else if (state == S_IDLE && frame_start)      stall_cnt <= '0;
    else if (state == S_RUN && !quad_xfer && stall_cnt != '1)
                                                  stall_cnt <= stall_cnt + 32'd1;
  end

  assign stat_stall_cycles = stall_cnt;
`else
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dc_ipu_line_seq.sv
// Self-checking bench for dc_ipu_line_seq: directed frames from the test plan
// plus randomized frames, checked against a line-level reference model.
module tb_dc_ipu_line_seq;

  localparam int TW = 12;
  localparam int FW = 8;
  localparam int CW = 3;
  localparam int YW = TW + FW;

  logic                 clk = 1'b0;
  logic                 nreset = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 frame_abort = 1'b0;
  logic [TW-1:0]        cfg_tex_width = '0;
  logic [TW-1:0]        cfg_tex_height = '0;
  logic [TW-1:0]        cfg_out_width = '0;
  logic [TW-1:0]        cfg_out_height = '0;
  logic [YW-1:0]        cfg_y_init = '0;
  logic [YW-1:0]        cfg_y_step = '0;
  logic                 bu_line_valid;
  logic                 bu_line_ready = 1'b0;
  logic [TW-1:0]        bu_line_y;
  logic                 g_ctl_start;
  logic                 g_ctl_abort;
  logic signed [CW-1:0] g_ctl_clamp_y;
  logic [TW-1:0]        g_ctl_tex_width;
  logic [FW-1:0]        line_fract_y;
  logic                 quad_xfer = 1'b0;
  logic                 busy;
  logic                 frame_done;
  logic [31:0]          stat_stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dc_ipu_line_seq #(
    .TEX_SIZE_WIDTH (TW),
    .TEX_FRACT_WIDTH(FW),
    .CLAMP_CTL_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .frame_start      (frame_start),
    .frame_abort      (frame_abort),
    .cfg_tex_width    (cfg_tex_width),
    .cfg_tex_height   (cfg_tex_height),
    .cfg_out_width    (cfg_out_width),
    .cfg_out_height   (cfg_out_height),
    .cfg_y_init       (cfg_y_init),
    .cfg_y_step       (cfg_y_step),
    .bu_line_valid    (bu_line_valid),
    .bu_line_ready    (bu_line_ready),
    .bu_line_y        (bu_line_y),
    .g_ctl_start      (g_ctl_start),
    .g_ctl_abort      (g_ctl_abort),
    .g_ctl_clamp_y    (g_ctl_clamp_y),
    .g_ctl_tex_width  (g_ctl_tex_width),
    .line_fract_y     (line_fract_y),
    .quad_xfer        (quad_xfer),
    .busy             (busy),
    .frame_done       (frame_done),
    .stat_stall_cycles(stat_stall_cycles)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference window for output line 'line' of a frame, from plain integer math.
  function automatic void win_model(input int yinit, input int ystep, input int line, input int h,
                                    output int by, output int cl, output int fr);
    int y, yi, r0;
    y  = (yinit + line * ystep) & 32'hFFFFF;
    fr = y & 255;
    if (y >= 524288) y = y - 1048576;
    yi = y >>> 8;
    r0 = yi - 1;
    by = (r0 < 0) ? 0 : r0;
    if (by > h - 4) by = h - 4;
    cl = r0 - by;
    if (cl > 3)  cl = 3;
    if (cl < -3) cl = -3;
  endfunction

  // One frame. rdy_hold >= 0: ready rises after that many valid cycles; -1: random.
  // xfer_pct < 0: quad_xfer alternates 0,1,0,1... in RUN. Abort selectors are -1 when unused.
  task automatic run_frame(input int h, input int tw, input int ow, input int oh,
                           input int yinit, input int ystep, input int rdy_hold, input int xfer_pct,
                           input int ab_run_line, input int ab_run_q, input int ab_req_line,
                           input int ab_end_line);
    int total, starts, ends, q, stalls, vcnt, rc, cyc, by, cl, fr;
    bit pv, p_rdy, p_hs, p_lastq, p_reqab, p_abort, p_fs, p_start;
    bit in_run, ab_sent, finished, rdy, xf, ev, es, ea, ed;
    longint exp_stat;
    @(negedge clk);
    cfg_tex_height = TW'(h);
    cfg_tex_width  = TW'(tw);
    cfg_out_width  = TW'(ow);
    cfg_out_height = TW'(oh);
    cfg_y_init     = YW'(yinit);
    cfg_y_step     = YW'(ystep);
    frame_start    = 1'b1;
    frame_abort    = 1'b0;
    total = oh; starts = 0; ends = 0; q = 0; stalls = 0; vcnt = 0; rc = 0; cyc = 0;
    pv = 0; p_rdy = 0; p_hs = 0; p_lastq = 0; p_reqab = 0; p_abort = 0; p_fs = 1; p_start = 0;
    in_run = 0; ab_sent = 0; finished = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      ev = p_fs || (p_abort && ends < total) || (pv && !p_rdy && !p_reqab);
      es = p_hs;
      ea = p_lastq;
      ed = p_reqab || (p_abort && ends == total);
      check_eq("bu_line_valid", bu_line_valid, ev);
      check_eq("g_ctl_start", g_ctl_start, es);
      check_eq("g_ctl_abort", g_ctl_abort, ea);
      check_eq("frame_done", frame_done, ed);
      check_eq("busy", busy, 1);
      if (ev) begin
        win_model(yinit, ystep, starts, h, by, cl, fr);
        check_eq("bu_line_y", bu_line_y, by);
      end
      if (es) begin
        win_model(yinit, ystep, starts, h, by, cl, fr);
        check_eq("g_ctl_clamp_y", g_ctl_clamp_y, cl);
        check_eq("line_fract_y", line_fract_y, fr);
        check_eq("g_ctl_tex_width", g_ctl_tex_width, tw);
        starts++;
        vcnt = 0;
      end
      if (ea) ends++;
      if (ed) finished = 1;

      // BU side
      p_reqab = 0;
      if (ev) begin
        vcnt++;
        if (rdy_hold >= 0) rdy = (vcnt > rdy_hold);
        else               rdy = 1'($urandom_range(0, 1));
        if (ab_req_line == starts && !ab_sent) begin
          rdy = 0;
          frame_abort = 1'b1;
          ab_sent = 1;
          total = starts;
          p_reqab = 1;
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      p_hs = ev && rdy;

      // Gather side
      if (p_start) begin
        in_run = 1;
        q = 0;
        rc = 0;
      end
      p_lastq = 0;
      if (in_run) begin
        if (xfer_pct < 0) xf = rc[0];
        else              xf = ($urandom_range(0, 99) < xfer_pct);
        rc++;
        if (xf) begin
          q++;
          if (starts - 1 == ab_run_line && q == ab_run_q && !ab_sent) begin
            frame_abort = 1'b1;
            ab_sent = 1;
            total = starts;
          end
          if (q == ow) begin
            p_lastq = 1;
            in_run = 0;
          end
        end else begin
          stalls++;
        end
      end else begin
        xf = 1'($urandom_range(0, 1));
      end

      if (ea && ends - 1 == ab_end_line && !ab_sent && ends < total) begin
        frame_abort = 1'b1;
        ab_sent = 1;
        total = ends;
      end

      // Disturb inputs that must be ignored while a frame is in flight.
      if ($urandom_range(0, 19) == 0) frame_start = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        cfg_tex_width  = TW'($urandom);
        cfg_tex_height = TW'($urandom_range(4, 100));
        cfg_out_width  = TW'($urandom_range(1, 9));
        cfg_out_height = TW'($urandom_range(1, 9));
        cfg_y_init     = YW'($urandom);
        cfg_y_step     = YW'($urandom);
      end
      bu_line_ready = rdy;
      quad_xfer     = xf;
      p_fs = 0; p_abort = ea; p_start = es; pv = ev; p_rdy = rdy;
    end
    if (!finished) check_eq("frame_timeout", 0, 1);
    check_eq("lines_started", starts, total);
    check_eq("lines_ended", ends, total);
    @(negedge clk);
    frame_start = 1'b0;
    frame_abort = 1'b0;
    exp_stat = stalls;
`ifndef DC_IPU_LINE_SEQ_STATS_EN
    exp_stat = 0;
`endif
    check_eq("stat_stall_cycles", stat_stall_cycles, exp_stat);
    check_eq("busy_after_frame", busy, 0);
    check_eq("frame_done_once", frame_done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, bu_line_valid, 0);
    check_eq({tag, "_bu_line_y"}, bu_line_y, 0);
    check_eq({tag, "_start"}, g_ctl_start, 0);
    check_eq({tag, "_abort"}, g_ctl_abort, 0);
    check_eq({tag, "_clamp"}, g_ctl_clamp_y, 0);
    check_eq({tag, "_tex_width"}, g_ctl_tex_width, 0);
    check_eq({tag, "_fract"}, line_fract_y, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, frame_done, 0);
    check_eq({tag, "_stat"}, stat_stall_cycles, 0);
  endtask

  initial begin
    int h, ow, oh, yi, st, rh, xp, mode, arl, arq, aql, ael;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nreset = 1'b1;

    // Directed frames
    run_frame(8, 100, 3, 4, 0, 'h200, 0, 100, -1, -1, -1, -1);      // basic
    run_frame(16, 50, 2, 1, 'hFFB00, 'h100, 0, 100, -1, -1, -1, -1); // low-edge clamp
    run_frame(16, 50, 2, 1, 'h01400, 'h100, 0, 100, -1, -1, -1, -1); // high-edge clamp
    run_frame(64, 30, 2, 3, 'h180, 'h0C0, 0, 100, -1, -1, -1, -1);   // fractions
    run_frame(32, 30, 2, 2, 'h500, 'h100, 5, 100, -1, -1, -1, -1);   // BU backpressure
    run_frame(16, 30, 3, 4, 0, 'h100, 0, 100, 0, 1, -1, -1);         // abort in RUN
    run_frame(16, 30, 3, 4, 0, 'h100, 0, 100, -1, -1, 1, -1);        // abort in REQ
    run_frame(16, 30, 3, 4, 0, 'h100, 0, 100, -1, -1, -1, 1);        // abort in END
    run_frame(16, 30, 3, 4, 0, 'h100, 0, 100, 0, 3, -1, -1);         // abort with last quad
    run_frame(16, 30, 4, 1, 0, 'h100, 0, -1, -1, -1, -1, -1);        // alternating quads
    run_frame(4095, 7, 2, 3, 'hFF000, 'hFFFFF, -1, 60, -1, -1, -1, -1);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      h  = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(4, 40));
      ow = $urandom_range(1, 5);
      oh = $urandom_range(1, 6);
      yi = int'($urandom & 32'hFFFFF);
      st = ($urandom_range(0, 3) == 0) ? int'($urandom & 32'hFFFFF) : int'($urandom_range(0, 'h800));
      rh = int'($urandom_range(0, 4)) - 1;
      xp = $urandom_range(30, 100);
      mode = $urandom_range(0, 3);
      arl = -1; arq = -1; aql = -1; ael = -1;
      if (mode == 1) begin arl = $urandom_range(0, oh - 1); arq = $urandom_range(1, ow); end
      if (mode == 2) aql = $urandom_range(0, oh - 1);
      if (mode == 3) ael = $urandom_range(0, oh - 1);
      run_frame(h, int'($urandom_range(0, 4095)), ow, oh, yi, st, rh, xp, arl, arq, aql, ael);
    end

    // Asynchronous reset in the middle of a line
    @(negedge clk);
    cfg_tex_height = 16; cfg_tex_width = 77; cfg_out_width = 3; cfg_out_height = 2;
    cfg_y_init = 'h01400; cfg_y_step = 'h100;
    frame_start = 1'b1; bu_line_ready = 1'b1; quad_xfer = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    #2 nreset = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    bu_line_ready = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
